// File: rtl/rv_m_pkg.sv
// Shared RV32M definitions: operand width, funct3 op encodings, and the
// multiply/divide sequencer states.
package rv_m_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } m_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } mdu_state_e;

   localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Magnitudes are processed unsigned over
// 32 steps, and the signs are applied in a single fix-up cycle.
//
// state | meaning
// IDLE  | waiting for an M-op; accepts the operands, or returns a fast-path result
// CALC  | one shift-add / restoring-divide step per cycle, counter 0..31
// FIX   | apply the signs, select the output half, write the result
// DONE  | valid_out high for this one cycle
module mul_div_unit
   import rv_m_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] opr_a,
   input  logic [XLEN-1:0] opr_b,
   input  logic            flush,
   output logic            stall,
   output logic            valid_out,
   output logic [XLEN-1:0] result
);

   function automatic logic [XLEN-1:0] abs_xlen(input logic [XLEN-1:0] val,
                                                input logic            signed_en);
      return (signed_en && val[XLEN-1]) ? (~val + 1'b1) : val;
   endfunction

   mdu_state_e        state;
   m_op_e             op_q;
   logic              sign_a;
   logic              sign_b;
   logic [4:0]        counter;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   b_abs;

   m_op_e             op_in;
   logic              sa_en;
   logic              sb_en;
   logic              fast;
   logic [XLEN-1:0]   fast_res;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     rem_sh;
   logic              rem_ge;
   logic [XLEN-1:0]   rem_new;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   fix_res;

   assign op_in = m_op_e'(op);
   assign sa_en = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                  (op_in == OP_DIV)  || (op_in == OP_REM);
   assign sb_en = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);

   always_comb begin
      fast     = 1'b0;
      fast_res = '0;
      if (op[2]) begin
         if (opr_b == '0) begin
            fast     = 1'b1;
            fast_res = op[1] ? opr_a : DIV0_Q;
         end else if ((op_in == OP_DIV || op_in == OP_REM) &&
                      opr_a == 32'h8000_0000 && opr_b == 32'hFFFF_FFFF) begin
            fast     = 1'b1;
            fast_res = op[1] ? '0 : opr_a;
         end
      end
   end

   // mul: high half accumulates with its carry; div: remainder in high, dividend/quotient in low
   assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_abs} : '0);
   assign rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
   assign rem_ge  = rem_sh >= {1'b0, b_abs};
   assign rem_new = rem_sh[XLEN-1:0] - b_abs;

   always_comb begin
      prod    = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
      fix_res = '0;
      case (op_q)
         OP_MUL:                     fix_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:
            fix_res = (sign_a ^ sign_b) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
         default:
            fix_res = sign_a ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
      endcase
   end

   assign stall = start & ~valid_out & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_MUL;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         counter   <= '0;
         acc       <= '0;
         b_abs     <= '0;
         valid_out <= 1'b0;
         result    <= '0;
      end else if (flush) begin
         state     <= IDLE;
         counter   <= '0;
         valid_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q    <= op_in;
                  sign_a  <= sa_en & opr_a[XLEN-1];
                  sign_b  <= sb_en & opr_b[XLEN-1];
                  acc     <= {{XLEN{1'b0}}, abs_xlen(opr_a, sa_en)};
                  b_abs   <= abs_xlen(opr_b, sb_en);
                  counter <= '0;
                  if (fast) begin
                     result    <= fast_res;
                     valid_out <= 1'b1;
                     state     <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (op_q[2])
                  acc <= {(rem_ge ? rem_new : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
               else
                  acc <= {mul_sum, acc[XLEN-1:1]};
               if (counter == 5'd31) begin
                  counter <= '0;
                  state   <= FIX;
               end else begin
                  counter <= counter + 5'd1;
               end
            end
            FIX: begin
               result    <= fix_res;
               valid_out <= 1'b1;
               state     <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, flush/reset
// corner sequences, back-to-back timing and randomized ops against a model.
module tb_mul_div_unit;
   import rv_m_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] opr_a;
   logic [31:0] opr_b;
   logic        flush;
   logic        stall;
   logic        valid_out;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   mul_div_unit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .op        (op),
      .opr_a     (opr_a),
      .opr_b     (opr_b),
      .flush     (flush),
      .stall     (stall),
      .valid_out (valid_out),
      .result    (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Plain-arithmetic view of the RV32M rules, independent of the iterative datapath.
   function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      longint      sa;
      longint      sb;
      longint      ub;
      logic [63:0] p;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (f3[2] && (b == 0)) return 1;
      if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 34;
   endfunction

   // Presents an op on a negedge and counts edges until valid_out is seen.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit scramble, output logic [31:0] res, output int lat,
                         output bit stall_ok);
      bit got;
      @(negedge clk);
      start = 1'b1; op = f3; opr_a = a; opr_b = b;
      lat = 0; got = 0; stall_ok = 1;
      while (!got && lat < 60) begin
         @(posedge clk); #1;
         lat++;
         if (valid_out) got = 1;
         else begin
            if (!stall) stall_ok = 0;
            if (scramble) begin
               opr_a = $urandom; opr_b = $urandom; op = 3'($urandom_range(0, 7));
            end
         end
      end
      if (!got) begin
         errors++;
         $display("FAIL timeout: no valid_out for op %0d within %0d cycles", f3, lat);
      end
      res = result;
   endtask

   task automatic idle_one();
      @(negedge clk);
      start = 1'b0;
   endtask

   vec_t        vecs[$];
   logic [31:0] res;
   logic [31:0] last_exp;
   int          lat;
   bit          sok;
   bit          seen;

   initial begin
      rst_n = 1'b0; start = 1'b0; op = '0; opr_a = '0; opr_b = '0; flush = 1'b0;
      #1;
      check("reset_result", result, 32'h0);
      check("reset_valid", {31'b0, valid_out}, 32'h0);
      check("reset_stall", {31'b0, stall}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
      vecs.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
      vecs.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
      vecs.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
      vecs.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
      vecs.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
      vecs.push_back('{3'd5, 32'd100,        32'd7,         32'd14,        34});
      vecs.push_back('{3'd7, 32'd100,        32'd7,         32'd2,         34});
      vecs.push_back('{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back('{3'd6, 32'd5,          32'd0,         32'd5,         1});
      vecs.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1});
      vecs.push_back('{3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34});
      vecs.push_back('{3'd7, 32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat, sok);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         check($sformatf("vec%0d_stall", i), {31'b0, sok}, 32'h1);
         last_exp = vecs[i].exp;
         idle_one();
      end

      // Flush after ten CALC iterations.
      @(negedge clk);
      start = 1'b1; op = 3'd5; opr_a = 32'd1000; opr_b = 32'd9;
      @(posedge clk);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_stall", {31'b0, stall}, 32'h0);
      @(posedge clk); #1;
      check("flush_valid", {31'b0, valid_out}, 32'h0);
      check("flush_result", result, last_exp);
      @(negedge clk);
      flush = 1'b0; start = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (valid_out) seen = 1;
      end
      check("flush_no_valid", {31'b0, seen}, 32'h0);
      check("flush_hold_result", result, last_exp);
      run_op(3'd5, 32'd9, 32'd3, 0, res, lat, sok);
      check("after_flush_divu", res, 32'd3);
      check("after_flush_latency", lat, 34);
      idle_one();

      // Reset twenty iterations into a multiply.
      @(negedge clk);
      start = 1'b1; op = 3'd0; opr_a = 32'd11; opr_b = 32'd13;
      @(posedge clk);
      repeat (20) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; start = 1'b0;
      #1;
      check("midop_reset_result", result, 32'h0);
      check("midop_reset_valid", {31'b0, valid_out}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (valid_out) seen = 1;
      end
      check("midop_reset_no_valid", {31'b0, seen}, 32'h0);

      run_op(3'd0, 32'd12345, 32'hFFFF_FD5A, 1, res, lat, sok);
      check("captured_operands", res, ref_mdu(3'd0, 32'd12345, 32'hFFFF_FD5A));
      idle_one();

      // Back-to-back: start stays high, so one IDLE cycle separates the runs.
      run_op(3'd0, 32'd3, 32'd5, 0, res, lat, sok);
      check("b2b_first", res, 32'd15);
      check("b2b_first_latency", lat, 34);
      run_op(3'd0, 32'd6, 32'd7, 0, res, lat, sok);
      check("b2b_second", res, 32'd42);
      check("b2b_second_latency", lat, 35);
      check("b2b_stall", {31'b0, sok}, 32'h1);
      idle_one();

      for (int n = 0; n < 30; n++) begin
         logic [2:0]  rf;
         logic [31:0] ra;
         logic [31:0] rb;
         rf = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 9))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 20));
            3: ra = 32'h8000_0000;
            default: ;
         endcase
         run_op(rf, ra, rb, 0, res, lat, sok);
         check($sformatf("rand%0d_op%0d_%h_%h", n, rf, ra, rb), res, ref_mdu(rf, ra, rb));
         check($sformatf("rand%0d_latency", n), lat, ref_lat(rf, ra, rb));
         idle_one();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
